// File: rtl/rsa_two_power_mod_multi.sv
// rsa_two_power_mod_multi: computes 2^P mod N by iterated modular doubling, STEP doublings per cycle
module rsa_two_power_mod_multi #(
    parameter int MOD_W = 256,
    parameter int CNT_W = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [CNT_W-1:0] i_power,
    input  logic [MOD_W-1:0] i_modulus,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [MOD_W-1:0] o_result,
    output logic             o_error
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
    state_t state;
    logic [MOD_W-1:0] r, n, nxt;
    logic [MOD_W:0] t;
    logic [CNT_W-1:0] rem, k;
    assign i_ready = state == IDLE;
    assign o_valid = state == DONE;
    assign o_result = r;
    assign k = rem < CNT_W'(STEP) ? rem : CNT_W'(STEP);
    // r < n always holds, so one conditional subtract per doubling keeps it reduced
    always_comb begin
        nxt = r;
        t = '0;
        for (int s = 0; s < STEP; s++) begin
            t = {nxt, 1'b0};
            nxt = CNT_W'(s) >= rem ? nxt : t >= {1'b0, n} ? MOD_W'(t - {1'b0, n}) : t[MOD_W-1:0];
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            r <= '0;
            rem <= '0;
            n <= '0;
            o_error <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    n <= i_modulus;
                    rem <= i_power;
                    o_error <= i_modulus == '0;
                    r <= MOD_W'(i_modulus > MOD_W'(1));
                    state <= i_modulus == '0 || i_power == '0 ? DONE : CALC;
                end
                CALC: begin
                    r <= nxt;
                    rem <= rem - k;
                    state <= rem == k ? DONE : CALC;
                end
                DONE: state <= o_ready ? IDLE : DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/rsa_two_power_mod_multi.md
Name: rsa_two_power_mod_multi

Overview:
- Computes R = 2^P mod N for a parametrised modulus width. Used to generate Montgomery/RSA pre-computation constants (e.g. 2^(2·MOD_W) mod N).
- Generalised successor of the fixed-width two-power-mod block. Adds:
  - configurable shift-subtract steps per cycle;
  - correct P=0, N=1 and N=0 handling;
  - a modulus-error flag;
  - registered, held output under valid/ready handshakes on both sides.

Parameters:
- MOD_W, 256, modulus and result width in bits (≥2).
- CNT_W, 32, width of the power operand and the remaining-count register.
- STEP, 1, number of doubling/reduction iterations per CALC cycle (1..8; forms a combinational chain of STEP stages).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_valid  input  1  request valid.
- i_ready  output  1  block can accept a request; high only in IDLE.
- i_power  input  CNT_W  exponent P, unsigned.
- i_modulus  input  MOD_W  modulus N, unsigned.
- o_valid  output  1  result valid; high only in DONE.
- o_ready  input  1  consumer accepts the result.
- o_result  output  MOD_W  2^P mod N, registered.
- o_error  output  1  high with o_valid when N==0.

Behaviour:
- Reset (asynchronous, rst low):
  - state=IDLE; result register, remaining count, latched modulus and o_error all 0.
  - Outputs: o_valid=0, o_result=0, o_error=0, i_ready=1.
  - Reset asserted mid-operation aborts the calculation silently; no result is produced.
- States: IDLE, CALC, DONE (2-bit encoding). An illegal state returns to IDLE.
- Accept: on a clk edge with i_valid && i_ready, latch N and P, and set rem=P. i_* inputs are ignored at all other times.
- Transitions and register updates on accept:
  - N==0: o_error<=1, r<=0, go to DONE.
  - N==1: r<=0, o_error<=0.
  - Otherwise: r<=1, o_error<=0.
  - If N!=0 and P==0: go to DONE; r already holds 1 mod N.
  - If N!=0 and P>0: go to CALC.
- CALC arithmetic, each cycle:
  - Perform k = min(STEP, rem) iterations of: t = 2r (MOD_W+1 bits); r = (t >= N) ? t−N : t.
  - Then rem <= rem−k.
  - Invariant r < N holds throughout, so a single conditional subtract suffices and the MOD_W+1-bit intermediate never overflows.
  - The comparison is >=, not >. A result equal to N must reduce to 0.
- CALC exit: go to DONE on the edge where rem−k == 0. The final r is registered on that same edge.
- Latency, counted from the accept edge to o_valid high:
  - P>0: ceil(P/STEP)+1 cycles.
  - P==0 or N==0: 1 cycle.
- DONE:
  - o_valid=1; o_result=r[MOD_W-1:0] and o_error are held stable until the handshake.
  - Go to IDLE on o_valid && o_ready; o_valid drops on the next cycle.
  - i_ready stays low in DONE. There is no same-cycle accept of a new request.
- Result handling: o_result keeps its last value in IDLE until the next result is written; it has no meaning while o_valid=0.
- Throughput: one request per (latency+1) cycles when o_ready is held high.
- P values up to 2^CNT_W−1 are supported. The remaining counter does not wrap, because k never exceeds rem.

Test Plan:
- Basic, STEP=1: N=13, P=10 -> o_result=10 (1024 mod 13), o_error=0, o_valid high 11 cycles after the accept edge.
- Multi-step, STEP=4, same stimulus: N=13, P=10 -> o_result=10, o_valid 4 cycles after accept. Also P=9 (remainder step): N=13, P=9 -> 5, 4 cycles.
- Exact-multiple boundary: N=16, P=4 -> 0; N=255, P=8 -> 1; MOD_W=256, N=2^255+1, P=256 -> 2^256 mod N (reference model). Checks the >= reduction.
- Degenerate operands:
  - P=0, N=13 -> 1 after 1 cycle.
  - N=1, P=5 -> 0.
  - N=0, P=7 -> o_error=1, o_result=0 after 1 cycle.
- Backpressure: hold o_ready=0 for 5 cycles in DONE -> o_valid, o_result and o_error stable; i_ready=0. Drive i_valid with garbage meanwhile -> it is ignored. After o_ready=1, i_ready=1 next cycle and a back-to-back request completes correctly.
- Reset mid-operation: assert rst during CALC of N=13, P=1000 -> same cycle: i_ready=1, o_valid=0, o_result=0. After release, a new request N=7, P=3 -> 1.
